// File: rtl/instr_fetch_pkg.sv
// Fetch-path constants shared with the instruction pointer and decoder.
// Optional feature macro used by this slice: FETCH_BYPASS_EN.
package instr_fetch_pkg;

  localparam int IF_ADDR_WIDTH     = 8;
  localparam int IF_DATA_WIDTH     = 128;
  localparam int IMEM_READ_LATENCY = 2;
  localparam int IF_FIFO_DEPTH     = 4;

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int countWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous instruction buffer with push/pop/clear, occupancy count and
// a registered head word; storage is reset so the head reads zero after reset.
module instr_fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int AW    = IF_ADDR_WIDTH,
  parameter int DW    = IF_DATA_WIDTH,
  parameter int DEPTH = IF_FIFO_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = countWidth(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          head_valid,
  output logic [CW-1:0] count
);

  logic [AW-1:0] r_addrMem [DEPTH];
  logic [DW-1:0] r_dataMem [DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_doPop;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_doPop    = pop && (r_count != '0);
  assign head_valid = (r_count != '0);
  assign head_addr  = r_addrMem[r_rdPtr];
  assign head_data  = r_dataMem[r_rdPtr];
  assign count      = r_count;

  // Clear wins over a same-cycle push or pop: everything buffered is stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addrMem[i] <= '0;
        r_dataMem[i] <= '0;
      end
    end else if (clear) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_addrMem[r_wrPtr] <= push_addr;
        r_dataMem[r_wrPtr] <= push_data;
        r_wrPtr            <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({push, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Upstream credits make a push into a full buffer impossible.
  always_ff @(posedge clk) begin
    if (!reset && !clear && push) begin
      assert (!w_full);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: credit-gated reads of instruction memory, in-flight tracking and
// buffered delivery to the decoder. Define FETCH_BYPASS_EN for same-cycle bypass.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH       = IF_ADDR_WIDTH,
  parameter int DATA_WIDTH       = IF_DATA_WIDTH,
  parameter int MEM_READ_LATENCY = IMEM_READ_LATENCY,
  parameter int FIFO_DEPTH       = IF_FIFO_DEPTH,
  localparam int CW              = countWidth(FIFO_DEPTH),
  localparam int OW              = CW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ptr_in,
  output logic                  ptr_enable,
  input  logic                  jump_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready
);

  localparam int L = MEM_READ_LATENCY;

  logic [L-1:0]          r_pipeValid;
  logic [ADDR_WIDTH-1:0] r_pipeAddr [L];
  logic [CW-1:0]         w_fifoCount;
  logic [CW-1:0]         w_inflight;
  logic [OW-1:0]         w_occupancy;
  logic                  w_issue;
  logic                  w_arrive;
  logic                  w_fifoValid;
  logic                  w_fifoPush;
  logic                  w_fifoPop;
  logic [ADDR_WIDTH-1:0] w_headAddr;
  logic [DATA_WIDTH-1:0] w_headData;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < L; i++) begin
      w_inflight = w_inflight + CW'(r_pipeValid[i]);
    end
  end

  // A jump discards all outstanding work, so the whole buffer is credit again.
  assign w_occupancy = jump_en ? '0 : (OW'(w_fifoCount) + OW'(w_inflight));
  assign w_issue     = !reset && (w_occupancy < OW'(FIFO_DEPTH));
  assign ptr_enable  = w_issue;
  assign mem_ren     = w_issue;
  assign mem_addr    = ptr_in;

  // Tail stage lines up with mem_data; a flush kills every older read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipeValid <= '0;
    end else begin
      r_pipeValid[0] <= w_issue;
      for (int i = 1; i < L; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1] && !jump_en;
      end
    end
    r_pipeAddr[0] <= ptr_in;
    for (int i = 1; i < L; i++) begin
      r_pipeAddr[i] <= r_pipeAddr[i-1];
    end
  end

  assign w_arrive = r_pipeValid[L-1] && !jump_en && !reset;

  always_comb begin
    instr_valid = w_fifoValid;
    instr_addr  = w_headAddr;
    instr_data  = w_headData;
    w_fifoPush  = w_arrive;
`ifdef FETCH_BYPASS_EN
    if (w_arrive && !w_fifoValid) begin
      instr_valid = 1'b1;
      instr_addr  = r_pipeAddr[L-1];
      instr_data  = mem_data;
      w_fifoPush  = !instr_ready;
    end
`endif
    w_fifoPop = w_fifoValid && instr_ready;
  end

  instr_fetch_fifo #(
    .AW    (ADDR_WIDTH),
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (jump_en),
    .push       (w_fifoPush),
    .push_addr  (r_pipeAddr[L-1]),
    .push_data  (mem_data),
    .pop        (w_fifoPop),
    .head_addr  (w_headAddr),
    .head_data  (w_headData),
    .head_valid (w_fifoValid),
    .count      (w_fifoCount)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus predicts issue, validity and accepted
// words from an outstanding-word queue; a negedge monitor compares the DUT.
`timescale 1ns/1ps
module tb_instr_fetch;

  localparam int AW    = 8;
  localparam int DW    = 128;
  localparam int L     = 2;
  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ptr_in;
  logic          ptr_enable;
  logic          jump_en;
  logic [AW-1:0] mem_addr;
  logic          mem_ren;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_addr;
  logic          instr_valid;
  logic          instr_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] addr;
    int            cyc;
  } pend_t;

  typedef struct {
    logic          care;
    logic          valid;
    logic          issue;
    logic [AW-1:0] addr;
  } cyc_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xfer_t;

  pend_t         pendQ[$];
  cyc_t          cycQ[$];
  xfer_t         xferQ[$];
  logic [AW-1:0] ptrReg = '0;
  int            cyc = 0;
  logic          memV [L];
  logic [AW-1:0] memA [L];
  cyc_t          monCyc;
  xfer_t         monXfer;

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .ptr_in      (ptr_in),
    .ptr_enable  (ptr_enable),
    .jump_en     (jump_en),
    .mem_addr    (mem_addr),
    .mem_ren     (mem_ren),
    .mem_data    (mem_data),
    .instr_data  (instr_data),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    logic [AW-1:0] b;
    b = ~a ^ 8'h3C;
    return {8{a, b}};
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: drive inputs after the edge, predict the response, then let the
  // memory model capture this cycle's read request.
  task automatic applyStimulus(input logic rst, input logic jmp, input logic [AW-1:0] tgt, input logic rdy);
    cyc_t  c;
    xfer_t x;
    pend_t p;
    logic  expValid;
    logic  expIssue;
    int    occ;
    int    lat;
    @(posedge clk);
    #1;
    reset       = rst;
    jump_en     = jmp;
    instr_ready = rdy && !rst;
    ptr_in      = jmp ? tgt : ptrReg;
    mem_data    = memV[L-1] ? memWord(memA[L-1]) : {$urandom, $urandom, $urandom, $urandom};
    lat         = (BYPASS && !jmp) ? L : L + 1;
    expValid    = (pendQ.size() > 0) && (cyc >= pendQ[0].cyc + lat);
    occ         = jmp ? 0 : pendQ.size();
    expIssue    = !rst && (occ < DEPTH);
    c.care  = !rst;
    c.valid = expValid;
    c.issue = expIssue;
    c.addr  = ptr_in;
    cycQ.push_back(c);
    if (!rst && expValid && rdy) begin
      x.addr = pendQ[0].addr;
      x.data = memWord(pendQ[0].addr);
      xferQ.push_back(x);
      void'(pendQ.pop_front());
    end
    if (rst || jmp) pendQ.delete();
    if (expIssue) begin
      p.addr = ptr_in;
      p.cyc  = cyc;
      pendQ.push_back(p);
    end
    ptrReg = expIssue ? ptr_in + 1'b1 : ptr_in;
    #1;
    for (int i = L - 1; i > 0; i--) begin
      memV[i] = memV[i-1];
      memA[i] = memA[i-1];
    end
    memV[0] = mem_ren;
    memA[0] = mem_addr;
    cyc++;
  endtask

  always @(negedge clk) begin
    if (cycQ.size() > 0) begin
      monCyc = cycQ.pop_front();
      checkOutput("mem_ren", DW'(mem_ren), DW'(monCyc.issue));
      checkOutput("ptr_enable", DW'(ptr_enable), DW'(monCyc.issue));
      if (monCyc.issue) checkOutput("mem_addr", DW'(mem_addr), DW'(monCyc.addr));
      if (monCyc.care) checkOutput("instr_valid", DW'(instr_valid), DW'(monCyc.valid));
      if (monCyc.care && instr_valid === 1'b1 && instr_ready === 1'b1) begin
        if (xferQ.size() == 0) begin
          checkOutput("unexpected_transfer_addr", DW'(instr_addr), '1);
        end else begin
          monXfer = xferQ.pop_front();
          checkOutput("instr_addr", DW'(instr_addr), DW'(monXfer.addr));
          checkOutput("instr_data", instr_data, monXfer.data);
        end
      end
    end
  end

  initial begin
    logic rs;
    logic jp;
    logic rd;
    reset       = 1'b1;
    jump_en     = 1'b0;
    instr_ready = 1'b0;
    ptr_in      = '0;
    mem_data    = '0;
    for (int i = 0; i < L; i++) begin
      memV[i] = 1'b0;
      memA[i] = '0;
    end

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    #2;
    checkOutput("reset_instr_valid", DW'(instr_valid), '0);
    checkOutput("reset_instr_data", instr_data, '0);
    checkOutput("reset_instr_addr", DW'(instr_addr), '0);
    ptrReg = '0;

    repeat (5) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (8) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h40, 1'b1);
    repeat (8) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h80, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'hFE, 1'b1);
    repeat (8) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 63) == 0);
      jp = ($urandom_range(0, 15) == 0);
      rd = ($urandom_range(0, 3) != 0);
      applyStimulus(rs, jp, 8'($urandom), rd);
    end

    repeat (12) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("leftover_transfers", DW'(xferQ.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
